// File: rtl/dmem_access_stage_pkg.sv
// Shared types for the data-memory access stage: FSM state encoding,
// byte-lane width and the registered writeback packet.
package dmem_access_stage_pkg;

  localparam int BE_W     = 4;
  localparam int WORD_W   = 32;
  localparam int RF_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  typedef struct packed {
    logic                v;
    logic                en;
    logic [RF_IDX_W-1:0] rd;
    logic [WORD_W-1:0]   data;
  } wb_pkt_t;

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering: store byte-enable/data replication and
// load byte extraction with zero extension.
module dmem_lane_steer
  import dmem_access_stage_pkg::*;
(
  input  logic              st_byte_i,
  input  logic [1:0]        st_lane_i,
  input  logic [WORD_W-1:0] st_data_i,
  output logic [BE_W-1:0]   st_be_o,
  output logic [WORD_W-1:0] st_wdata_o,
  input  logic              ld_byte_i,
  input  logic [1:0]        ld_lane_i,
  input  logic [WORD_W-1:0] ld_rdata_i,
  output logic [WORD_W-1:0] ld_data_o
);

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    if (st_byte_i) begin
      st_be_o    = BE_W'(1) << st_lane_i;
      // The byte is replicated so memory can pick it up from whichever lane is enabled.
      st_wdata_o = {4{st_data_i[7:0]}};
    end
  end

  always_comb begin
    ld_data_o = ld_rdata_i;
    if (ld_byte_i) begin
      ld_data_o = {24'b0, ld_rdata_i[{ld_lane_i, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/dmem_access_stage.sv
// Memory-access pipeline stage: sequences one data-memory request/response
// per instruction and emits a one-cycle registered writeback packet.
module dmem_access_stage
  import dmem_access_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RF_ADDR_W   = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 is_load_op_i,
  input  logic                 is_store_op_i,
  input  logic                 is_mem_op_i,
  input  logic                 is_byte_op_i,
  input  logic                 op_writes_rf_i,
  input  logic [RF_ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]    alu_result_i,
  input  logic [DATA_W-1:0]    store_data_i,
  output logic                 dmem_req_v_o,
  input  logic                 dmem_req_yumi_i,
  output logic [ADDR_W-1:0]    dmem_addr_o,
  output logic                 dmem_we_o,
  output logic [BE_W-1:0]      dmem_be_o,
  output logic [DATA_W-1:0]    dmem_wdata_o,
  input  logic                 dmem_resp_v_i,
  input  logic [DATA_W-1:0]    dmem_rdata_i,
  output logic                 wb_v_o,
  output logic                 wb_en_o,
  output logic [RF_ADDR_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic                 stall_o,
  output logic                 err_misalign_o,
  output logic                 err_timeout_o,
  output state_e               dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  // Handshakes: upstream transfers when valid_i && ready_o; the memory request
  // transfers when dmem_req_v_o && dmem_req_yumi_i, and its fields stay frozen
  // until then. dmem_resp_v_i carries no back-pressure and is only honoured in
  // WAIT_RESP.
  state_e               state;
  logic [CNT_W-1:0]     tmo_cnt;
  logic [1:0]           lane_q;
  logic                 load_q;
  logic                 byte_q;
  logic                 wr_rf_q;
  logic [RF_ADDR_W-1:0] rd_q;
  wb_pkt_t              wb_q;

  logic [BE_W-1:0]      st_be;
  logic [DATA_W-1:0]    st_wdata;
  logic [DATA_W-1:0]    ld_data;
  logic                 mem_aligned;

  assign mem_aligned = is_byte_op_i || (alu_result_i[1:0] == 2'b00);

  dmem_lane_steer u_lane_steer (
    .st_byte_i  (is_byte_op_i),
    .st_lane_i  (alu_result_i[1:0]),
    .st_data_i  (store_data_i),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_byte_i  (byte_q),
    .ld_lane_i  (lane_q),
    .ld_rdata_i (dmem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      lane_q         <= '0;
      load_q         <= 1'b0;
      byte_q         <= 1'b0;
      wr_rf_q        <= 1'b0;
      rd_q           <= '0;
      wb_q           <= '0;
      dmem_req_v_o   <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_we_o      <= 1'b0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      err_misalign_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (!is_mem_op_i) begin
              wb_q  <= '{v: 1'b1, en: op_writes_rf_i, rd: rd_addr_i, data: alu_result_i};
              state <= ST_DONE;
            end else if (!mem_aligned) begin
              wb_q           <= '{v: 1'b1, en: 1'b0, rd: rd_addr_i, data: alu_result_i};
              err_misalign_o <= 1'b1;
              state          <= ST_DONE;
            end else begin
              lane_q       <= alu_result_i[1:0];
              load_q       <= is_load_op_i;
              byte_q       <= is_byte_op_i;
              wr_rf_q      <= op_writes_rf_i;
              rd_q         <= rd_addr_i;
              dmem_req_v_o <= 1'b1;
              dmem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
              dmem_we_o    <= is_store_op_i;
              dmem_be_o    <= st_be;
              dmem_wdata_o <= st_wdata;
              state        <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_yumi_i) begin
            dmem_req_v_o <= 1'b0;
            tmo_cnt      <= '0;
            state        <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (dmem_resp_v_i) begin
            // A store's response is just the write acknowledgement.
            wb_q  <= '{v: 1'b1, en: load_q & wr_rf_q, rd: rd_q,
                       data: load_q ? ld_data : '0};
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              wb_q          <= '{v: 1'b1, en: 1'b0, rd: rd_q, data: '0};
              err_timeout_o <= 1'b1;
              state         <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          wb_q.v         <= 1'b0;
          err_misalign_o <= 1'b0;
          err_timeout_o  <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o     = (state == ST_IDLE);
  assign stall_o     = ~ready_o;
  assign wb_v_o      = wb_q.v;
  assign wb_en_o     = wb_q.en;
  assign wb_rd_o     = wb_q.rd;
  assign wb_data_o   = wb_q.data;
  assign dbg_state_o = state;

endmodule
